program_sequencer_isr: RTL and testbench
========================================

# program_sequencer_isr

Program sequencer for the 4-bit CPU that services the computational unit's timer interrupt. It receives `interrupt`, redirects instruction fetch to a fixed ISR vector, holds `isr` high while the service routine runs, and on return-from-interrupt resumes at the saved address. It produces the program-memory address each cycle from the jump controls supplied by the instruction decoder, and it drives the `isr` input of the computational unit.

## Interface
Parameters:
- `ISR_VECTOR`, default 8'hF0: program-memory address of the service routine.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `sync_reset` input, 1 bit: synchronous, active-high reset.
- `jmp` input, 1 bit: unconditional jump.
- `jmp_nz` input, 1 bit: jump if not zero.
- `dont_jmp` input, 1 bit: condition from `r_eq_0`; when 1, a `jmp_nz` is suppressed.
- `jmp_addr` input, 4 bits: jump target page; target = {jmp_addr, 4'h0}.
- `interrupt` input, 1 bit: request from the computational unit, one cycle wide.
- `rti` input, 1 bit: return-from-interrupt instruction decoded.
- `pm_addr` output, 8 bits: combinational next fetch address.
- `pc` output, 8 bits: registered address of the instruction currently executing.
- `isr` output, 1 bit: registered; high while in the service routine.
- `from_PS` output, 8 bits: debug; equals `saved_pc`.

## Operation
- The FSM has two states, MAIN and ISR. The `isr` output is 1 exactly when the FSM is in ISR.
- `normal_next` is computed in priority order:
  - `jmp` → {jmp_addr, 4'h0}
  - else `jmp_nz && !dont_jmp` → {jmp_addr, 4'h0}
  - else `pc + 1`, computed mod 256 so 8'hFF wraps to 8'h00.
- `pm_addr` is computed in priority order:
  - `sync_reset` → 8'h00
  - else `interrupt && state==MAIN` → ISR_VECTOR
  - else `rti && state==ISR` → saved_pc
  - else `normal_next`
- Transitions:
  - MAIN→ISR when `interrupt`. In the same edge, `saved_pc` ← `normal_next`. A jump in flight at the moment of interrupt is therefore resumed at its target, not at pc+1.
  - ISR→MAIN when `rti`.
  - All other cycles hold state and hold `saved_pc`.
- `interrupt` while in ISR is dropped. No pending latch exists, and nesting is not allowed.
- `rti` while in MAIN has no control effect; `pm_addr` takes `normal_next`.
- If `rti` and `interrupt` arrive in the same ISR cycle, `rti` wins: return to MAIN and the interrupt is dropped.
- `pc` ← `pm_addr` on every edge.

## Timing
- Reset values, applied at the first edge with `sync_reset`=1: `pc`=8'h00, `isr`=0, `saved_pc`=8'h00, state=MAIN, `from_PS`=8'h00. `pm_addr`=8'h00 combinationally while reset is asserted.
- Reset in the middle of an ISR aborts it at the next edge: `isr`=0 and the saved address is lost.
- Latency:
  - `interrupt` in cycle n → `pm_addr`=ISR_VECTOR in cycle n (combinational) → `pc`=ISR_VECTOR and `isr`=1 in cycle n+1.
  - `rti` in cycle m → `pm_addr`=saved_pc in cycle m → `isr`=0 and `pc`=saved_pc in cycle m+1.
- `isr` is registered so the computational unit's gating of `interrupt` is glitch-free.
- With the computational unit, the timer period is `y1`+1 cycles. Any ISR that stays in ISR across a `timer`==1 cycle loses that interrupt.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum {MAIN, ISR}
  - the default ISR_VECTOR constant
  - the widths PM_AW=8 and PAGE_W=4
- One sub-module is natural: `next_addr_mux`, a combinational block that computes `normal_next` and `pm_addr`. The top level holds the FSM and the `pc`/`saved_pc` registers.

## Test plan
1. Reset, then idle with no jumps for 260 cycles → `pc` runs 0,1,…,FF,00,…; `isr`=0 throughout.
2. Set `pc`=8'h12 and pulse `interrupt` → `pm_addr`=F0 in that cycle; next cycle `pc`=F0, `isr`=1, `from_PS`=8'h13. Three cycles later pulse `rti` → `pc`=13, `isr`=0.
3. `interrupt` in the same cycle as `jmp` with `jmp_addr`=4'h5 → `pc`=F0 and `saved_pc`=50. After `rti`, `pc`=50.
4. `jmp_nz` with `dont_jmp`=1 at `pc`=8'h20, interrupt in the same cycle → `saved_pc`=21. Repeat with `dont_jmp`=0 and `jmp_addr`=4'h3 → `saved_pc`=30.
5. In ISR, pulse `interrupt` alone → ignored, `saved_pc` unchanged. Then assert `interrupt` and `rti` together → `isr`=0 next cycle, return address taken, no re-entry. `rti` pulsed in MAIN → `pc` increments normally.
6. `sync_reset` asserted while `isr`=1 at `pc`=F3 → next edge `pc`=00, `isr`=0, `from_PS`=00. Run with the computational unit, `y1`=4 → `isr` rises once every 5 cycles when the ISR is a single `rti` at F0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 4-bit CPU program
//               sequencer: sequencer state encoding, address widths and
//               the default interrupt service routine vector.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Program-memory address width and jump-page width
    localparam int PM_AW  = 8;
    localparam int PAGE_W = 4;

    // Default program-memory address of the interrupt service routine
    localparam logic [PM_AW-1:0] C_ISR_VECTOR_DEFAULT = 8'hF0;

    // Sequencer state: running main code or servicing the interrupt
    typedef enum logic [0:0] {
        MAIN = 1'b0,
        ISR  = 1'b1
    } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/next_addr_mux.sv
`default_nettype none
// ============================================================================
// Module      : next_addr_mux
// Description : Combinational next-address selection. Produces the
//               sequential/jump successor (normal_next) and the final fetch
//               address (pm_addr) including reset, ISR entry and ISR return.
// Revision    : 1.0 - initial release
// ============================================================================
module next_addr_mux
    import cpu_pkg::*;
#(
    parameter logic [PM_AW-1:0] ISR_VECTOR = C_ISR_VECTOR_DEFAULT
) (
    input  logic              sync_reset,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jmp,
    input  logic [PAGE_W-1:0] jmp_addr,
    input  logic              interrupt,
    input  logic              rti,
    input  state_t            state,
    input  logic [PM_AW-1:0]  pc,
    input  logic [PM_AW-1:0]  saved_pc,
    output logic [PM_AW-1:0]  normal_next,
    output logic [PM_AW-1:0]  pm_addr
);

    localparam logic [PM_AW-1:0] C_ONE = 1;

    logic [PM_AW-1:0] w_jump_target;

    assign w_jump_target = {jmp_addr, {(PM_AW-PAGE_W){1'b0}}};

    // Successor address of ordinary program flow: jump target or pc+1 (wraps)
    always_comb begin
        normal_next = pc + C_ONE;
        if (jmp) begin
            normal_next = w_jump_target;
        end else if (jmp_nz && !dont_jmp) begin
            normal_next = w_jump_target;
        end
    end

    // Fetch address: reset, ISR entry and ISR return override ordinary flow
    always_comb begin
        pm_addr = normal_next;
        if (sync_reset) begin
            pm_addr = '0;
        end else if (interrupt && (state == MAIN)) begin
            pm_addr = ISR_VECTOR;
        end else if (rti && (state == ISR)) begin
            pm_addr = saved_pc;
        end
    end

endmodule : next_addr_mux
`default_nettype wire

// File: rtl/program_sequencer_isr.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_isr
// Description : Program sequencer with single-level timer interrupt support.
//               Redirects fetch to ISR_VECTOR on interrupt, saves the
//               resume address, holds isr high during service and returns
//               to the saved address on rti. Interrupts during service are
//               dropped (no pending latch, no nesting).
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer_isr
    import cpu_pkg::*;
#(
    parameter logic [PM_AW-1:0] ISR_VECTOR = C_ISR_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic              dont_jmp,
    input  logic [PAGE_W-1:0] jmp_addr,
    input  logic              interrupt,
    input  logic              rti,
    output logic [PM_AW-1:0]  pm_addr,
    output logic [PM_AW-1:0]  pc,
    output logic              isr,
    output logic [PM_AW-1:0]  from_PS
);

    state_t           r_state;
    logic             r_isr;
    logic [PM_AW-1:0] r_pc;
    logic [PM_AW-1:0] r_saved_pc;
    logic [PM_AW-1:0] w_normal_next;
    logic [PM_AW-1:0] w_pm_addr;

    next_addr_mux #(
        .ISR_VECTOR (ISR_VECTOR)
    ) u_next_addr_mux (
        .sync_reset  (sync_reset),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .jmp_addr    (jmp_addr),
        .interrupt   (interrupt),
        .rti         (rti),
        .state       (r_state),
        .pc          (r_pc),
        .saved_pc    (r_saved_pc),
        .normal_next (w_normal_next),
        .pm_addr     (w_pm_addr)
    );

    // FSM, program counter and resume-address register; isr is registered
    // alongside the state so the computational unit sees a glitch-free gate.
    // The resume address is the successor the interrupted instruction would
    // have fetched, so an in-flight jump resumes at its target.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state    <= MAIN;
            r_isr      <= 1'b0;
            r_pc       <= '0;
            r_saved_pc <= '0;
        end else begin
            r_pc <= w_pm_addr;
            case (r_state)
                MAIN: begin
                    if (interrupt) begin
                        r_state    <= ISR;
                        r_isr      <= 1'b1;
                        r_saved_pc <= w_normal_next;
                    end
                end
                ISR: begin
                    // rti wins over a coincident interrupt; the interrupt is dropped
                    if (rti) begin
                        r_state <= MAIN;
                        r_isr   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= MAIN;
                    r_isr   <= 1'b0;
                end
            endcase
        end
    end

    assign pm_addr = w_pm_addr;
    assign pc      = r_pc;
    assign isr     = r_isr;
    assign from_PS = r_saved_pc;

endmodule : program_sequencer_isr
`default_nettype wire

// File: tb/tb_program_sequencer_isr.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer_isr
// Description : Self-checking bench for program_sequencer_isr: reset, free
//               run with wrap, directed vector table for jumps/ISR entry and
//               return, reset during ISR, and a timer-driven interrupt loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer_isr;

    typedef struct {
        logic       rst;
        logic       jmp;
        logic       jnz;
        logic       dj;
        logic [3:0] ja;
        logic       intr;
        logic       rti;
        logic [7:0] e_pm;
        logic [7:0] e_pc;
        logic       e_isr;
        logic [7:0] e_fps;
    } vec_t;

    localparam int NV = 26;

    logic       clk;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic [3:0] jmp_addr;
    logic       interrupt;
    logic       rti;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic       isr;
    logic [7:0] from_PS;

    int   total;
    int   bad;
    vec_t vt [NV];

    program_sequencer_isr #(
        .ISR_VECTOR (8'hF0)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .dont_jmp   (dont_jmp),
        .jmp_addr   (jmp_addr),
        .interrupt  (interrupt),
        .rti        (rti),
        .pm_addr    (pm_addr),
        .pc         (pc),
        .isr        (isr),
        .from_PS    (from_PS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst_i, input logic jmp_i, input logic jnz_i,
                                input logic dj_i, input logic [3:0] ja_i,
                                input logic intr_i, input logic rti_i,
                                input logic [7:0] pm_i, input logic [7:0] pc_i,
                                input logic isr_i, input logic [7:0] fps_i);
        vec_t v;
        v.rst = rst_i; v.jmp = jmp_i; v.jnz = jnz_i; v.dj = dj_i; v.ja = ja_i;
        v.intr = intr_i; v.rti = rti_i;
        v.e_pm = pm_i; v.e_pc = pc_i; v.e_isr = isr_i; v.e_fps = fps_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic j, input logic jn, input logic d,
                         input logic [3:0] a, input logic it, input logic rt);
        sync_reset = r; jmp = j; jmp_nz = jn; dont_jmp = d;
        jmp_addr = a; interrupt = it; rti = rt;
    endtask

    // Apply one vector at the falling edge, check pm_addr before the rising
    // edge and the registered outputs just after it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.rst, v.jmp, v.jnz, v.dj, v.ja, v.intr, v.rti);
        #1;
        chk($sformatf("v%0d pm_addr", idx), pm_addr, v.e_pm);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pc", idx), pc, v.e_pc);
        chk($sformatf("v%0d isr", idx), {7'b0, isr}, {7'b0, v.e_isr});
        chk($sformatf("v%0d from_PS", idx), from_PS, v.e_fps);
    endtask

    initial begin
        vec_t vr;
        logic [7:0] exp_pc;
        int   t;
        int   rises;
        int   last_rise;
        logic prev_isr;

        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Reset
        vr = mk(1,0,0,0,4'h0,0,0, 8'h00, 8'h00, 0, 8'h00);
        apply(vr, -1);

        // Free run 260 cycles from 00: wraps FF -> 00, isr stays low
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
            exp_pc = 8'(i + 1);
            #1;
            chk("run pm_addr", pm_addr, exp_pc);
            @(posedge clk);
            #1;
            chk("run pc", pc, exp_pc);
            chk("run isr", {7'b0, isr}, 8'h00);
        end

        // pc is now 04. Directed table:
        //         rst jmp jnz dj ja  int rti  pm     pc    isr fps
        vt[0]  = mk(0, 1, 0, 0, 4'h1, 0, 0, 8'h10, 8'h10, 0, 8'h00);
        vt[1]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'h11, 8'h11, 0, 8'h00);
        vt[2]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'h12, 8'h12, 0, 8'h00);
        vt[3]  = mk(0, 0, 0, 0, 4'h0, 1, 0, 8'hF0, 8'hF0, 1, 8'h13); // enter ISR
        vt[4]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'hF1, 8'hF1, 1, 8'h13);
        vt[5]  = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'hF2, 8'hF2, 1, 8'h13);
        vt[6]  = mk(0, 0, 0, 0, 4'h0, 1, 0, 8'hF3, 8'hF3, 1, 8'h13); // intr in ISR dropped
        vt[7]  = mk(0, 0, 0, 0, 4'h0, 0, 1, 8'h13, 8'h13, 0, 8'h13); // return
        vt[8]  = mk(0, 0, 0, 0, 4'h0, 0, 1, 8'h14, 8'h14, 0, 8'h13); // rti in MAIN
        vt[9]  = mk(0, 1, 0, 0, 4'h5, 1, 0, 8'hF0, 8'hF0, 1, 8'h50); // jmp + intr
        vt[10] = mk(0, 0, 0, 0, 4'h0, 0, 1, 8'h50, 8'h50, 0, 8'h50);
        vt[11] = mk(0, 1, 0, 0, 4'h2, 0, 0, 8'h20, 8'h20, 0, 8'h50);
        vt[12] = mk(0, 0, 1, 1, 4'h7, 1, 0, 8'hF0, 8'hF0, 1, 8'h21); // jnz suppressed
        vt[13] = mk(0, 0, 0, 0, 4'h0, 0, 1, 8'h21, 8'h21, 0, 8'h21);
        vt[14] = mk(0, 1, 0, 0, 4'h2, 0, 0, 8'h20, 8'h20, 0, 8'h21);
        vt[15] = mk(0, 0, 1, 0, 4'h3, 1, 0, 8'hF0, 8'hF0, 1, 8'h30); // jnz taken
        vt[16] = mk(0, 0, 0, 0, 4'h0, 1, 1, 8'h30, 8'h30, 0, 8'h30); // rti beats intr
        vt[17] = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'h31, 8'h31, 0, 8'h30); // no re-entry
        vt[18] = mk(0, 0, 0, 0, 4'h0, 1, 0, 8'hF0, 8'hF0, 1, 8'h32);
        vt[19] = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'hF1, 8'hF1, 1, 8'h32);
        vt[20] = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'hF2, 8'hF2, 1, 8'h32);
        vt[21] = mk(0, 0, 0, 0, 4'h0, 0, 0, 8'hF3, 8'hF3, 1, 8'h32);
        vt[22] = mk(1, 1, 0, 0, 4'h9, 1, 1, 8'h00, 8'h00, 0, 8'h00); // reset mid-ISR
        vt[23] = mk(0, 1, 1, 1, 4'hA, 0, 0, 8'hA0, 8'hA0, 0, 8'h00); // jmp ignores dont_jmp
        vt[24] = mk(0, 0, 1, 0, 4'h4, 0, 0, 8'h40, 8'h40, 0, 8'h00);
        vt[25] = mk(0, 1, 0, 0, 4'hF, 0, 1, 8'hF0, 8'hF0, 0, 8'h00); // F0 in MAIN, not ISR

        for (int i = 0; i < NV; i++) begin
            apply(vt[i], i);
        end

        // Timer model with y1=4 (period 5), interrupt gated by isr, ISR = rti at F0
        t         = 0;
        rises     = 0;
        last_rise = -1;
        prev_isr  = isr;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0,
                  (t == 4) && !isr, isr && (pc == 8'hF0));
            t = (t == 4) ? 0 : t + 1;
            @(posedge clk);
            #1;
            if (isr && !prev_isr) begin
                rises++;
                chk("timer isr pc", pc, 8'hF0);
                if (last_rise >= 0) begin
                    chk("timer isr spacing", 8'(c - last_rise), 8'd5);
                end
                last_rise = c;
            end
            prev_isr = isr;
        end
        chk("timer isr rises", 8'(rises), 8'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_program_sequencer_isr
`default_nettype wire
